// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and 4-beat burst sequencer for the shared
// four-word line memory, serving the instruction (I) and data (D) sides.
// Optional build macro MEM_STALL_EN adds a mem_stall input that freezes the
// current beat while asserted.
module mem_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              req_d,
  input  logic              wr_d,
  input  logic [ADDR_W-1:0] addr_d,
`ifdef MEM_STALL_EN
  input  logic              mem_stall,
`endif
  output logic              gnt_i,
  output logic              gnt_d,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        word_idx,
  output logic              done_i,
  output logic              done_d,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  state_t              state, state_nxt;
  owner_t              owner, owner_nxt;
  logic                last_d, last_d_nxt;
  logic [1:0]          count, count_nxt;
  logic [ADDR_W-4:0]   base;
  logic                wr;
  logic                grant;
  logic                pick_d;
  logic                stall;

`ifdef MEM_STALL_EN
  assign stall = mem_stall;
`else
  assign stall = 1'b0;
`endif

  // Byte-offset bits are not part of the line base; collected here on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[2:0], addr_d[2:0]};

  // Control registers: FSM state, beat counter, current and previous owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= OWN_NONE;
      last_d <= 1'b0;
      count  <= 2'd0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last_d <= last_d_nxt;
      count  <= count_nxt;
    end
  end

  // Burst data: line base and write flag captured at grant, held for all beats.
  always_ff @(posedge clk) begin
    if (grant) begin
      base <= pick_d ? addr_d[ADDR_W-1:3] : addr_i[ADDR_W-1:3];
      wr   <= pick_d & wr_d;
    end
  end

  // Arbitration, beat sequencing and output decode.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    last_d_nxt = last_d;
    count_nxt  = count;
    grant      = 1'b0;
    pick_d     = 1'b0;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    word_idx   = 2'd0;
    done_i     = 1'b0;
    done_d     = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the side that did not own the previous burst wins.
        if (req_i && (!req_d || last_d)) begin
          grant  = 1'b1;
          pick_d = 1'b0;
        end else if (req_d) begin
          grant  = 1'b1;
          pick_d = 1'b1;
        end
        if (grant) begin
          state_nxt = BURST;
          owner_nxt = pick_d ? OWN_D : OWN_I;
          count_nxt = 2'd0;
        end
      end

      BURST: begin
        gnt_i    = (owner == OWN_I);
        gnt_d    = (owner == OWN_D);
        mem_en   = 1'b1;
        busy     = 1'b1;
        mem_wr   = wr;
        word_idx = count;
        mem_addr = {base, count, 1'b0};
        if (!stall) begin
          count_nxt = count + 2'd1;
          if (count == 2'd3) begin
            done_i     = (owner == OWN_I);
            done_d     = (owner == OWN_D);
            state_nxt  = IDLE;
            last_d_nxt = (owner == OWN_D);
            owner_nxt  = OWN_NONE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Outputs are packed into one vector and compared against hand-computed values.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_i;
  logic [ADDR_W-1:0] addr_i;
  logic              req_d;
  logic              wr_d;
  logic [ADDR_W-1:0] addr_d;
`ifdef MEM_STALL_EN
  logic              mem_stall;
`endif
  logic              gnt_i, gnt_d, mem_en, mem_wr, done_i, done_d, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        word_idx;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .req_d    (req_d),
    .wr_d     (wr_d),
    .addr_d   (addr_d),
`ifdef MEM_STALL_EN
    .mem_stall(mem_stall),
`endif
    .gnt_i    (gnt_i),
    .gnt_d    (gnt_d),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .word_idx (word_idx),
    .done_i   (done_i),
    .done_d   (done_d),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Order: gnt_i gnt_d mem_en mem_wr busy done_i done_d word_idx[1:0] mem_addr[15:0]
  logic [24:0] obs;
  assign obs = {gnt_i, gnt_d, mem_en, mem_wr, busy, done_i, done_d, word_idx, mem_addr};

  function automatic logic [24:0] pack(input logic gi, input logic gd, input logic en,
                                       input logic wr, input logic bz, input logic di,
                                       input logic dd, input int idx, input int a);
    logic [1:0]  i2;
    logic [15:0] a16;
    i2  = idx[1:0];
    a16 = a[15:0];
    return {gi, gd, en, wr, bz, di, dd, i2, a16};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_i = 1'b0; req_d = 1'b0; wr_d = 1'b0;
    addr_i = '0; addr_d = '0;
`ifdef MEM_STALL_EN
    mem_stall = 1'b0;
`endif
    step(); step();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", obs, 25'd0);
    end
  endtask

  task automatic test_single_i();
    logic [24:0] e;
    rst = 1'b1; req_i = 1'b1; addr_i = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      step();
      e = pack(1, 0, 1, 0, 1, k == 3, 0, k, 16'h1230 + 2 * k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_i beat%0d: got %h want %h", k, obs, e);
      end
    end
    req_i = 1'b0;
    step();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL single_i idle: got %h want %h", obs, 25'd0);
    end
  endtask

  task automatic test_tie_round_robin();
    logic [24:0] e;
    logic        d;
    int          b0;
    rst = 1'b0; req_i = 1'b0; req_d = 1'b0;
    step();
    rst = 1'b1; req_i = 1'b1; req_d = 1'b1; wr_d = 1'b0;
    addr_i = 16'h0100; addr_d = 16'h0040;
    for (int b = 0; b < 3; b++) begin
      d  = (b != 1);
      b0 = d ? 16'h0040 : 16'h0100;
      for (int k = 0; k < 4; k++) begin
        step();
        e = pack(!d, d, 1, 0, 1, !d && k == 3, d && k == 3, k, b0 + 2 * k);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL tie burst%0d beat%0d: got %h want %h", b, k, obs, e);
        end
      end
      if (b == 2) begin
        req_i = 1'b0; req_d = 1'b0;
      end
      step();
      checks++;
      if (obs !== 25'd0) begin
        errors++;
        $display("FAIL tie turnaround%0d: got %h want %h", b, obs, 25'd0);
      end
    end
  endtask

  task automatic test_drop_mid_burst();
    logic [24:0] e;
    req_i = 1'b1; addr_i = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 1) req_i = 1'b0;
      e = pack(1, 0, 1, 0, 1, k == 3, 0, k, 16'h0020 + 2 * k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL drop beat%0d: got %h want %h", k, obs, e);
      end
    end
    step();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL drop idle: got %h want %h", obs, 25'd0);
    end
  endtask

  task automatic test_write_d();
    logic [24:0] e;
    req_d = 1'b1; wr_d = 1'b1; addr_d = 16'h00F8;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 1) begin
        addr_d = 16'hFFFF; wr_d = 1'b0;
      end
      e = pack(0, 1, 1, 1, 1, 0, k == 3, k, 16'h00F8 + 2 * k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL write_d beat%0d: got %h want %h", k, obs, e);
      end
    end
    req_d = 1'b0;
    step();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL write_d idle: got %h want %h", obs, 25'd0);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [24:0] e;
    // Previous burst was D, so without reset a tie would go to I.
    req_i = 1'b1; addr_i = 16'h0300;
    for (int k = 0; k < 3; k++) begin
      step();
      e = pack(1, 0, 1, 0, 1, 0, 0, k, 16'h0300 + 2 * k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_mid beat%0d: got %h want %h", k, obs, e);
      end
    end
    rst = 1'b0; req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (obs !== 25'd0) begin
        errors++;
        $display("FAIL rst_mid held%0d: got %h want %h", k, obs, 25'd0);
      end
    end
    rst = 1'b1; req_i = 1'b1; req_d = 1'b1; wr_d = 1'b0;
    addr_i = 16'h0500; addr_d = 16'h0400;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin
        req_i = 1'b0; req_d = 1'b0;
      end
      e = pack(0, 1, 1, 0, 1, 0, k == 3, k, 16'h0400 + 2 * k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_mid tie beat%0d: got %h want %h", k, obs, e);
      end
    end
    step();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL rst_mid idle: got %h want %h", obs, 25'd0);
    end
  endtask

`ifdef MEM_STALL_EN
  task automatic test_stall();
    logic [24:0] e;
    int          exp_idx [7] = '{0, 1, 1, 1, 2, 3, 3};
    req_i = 1'b1; addr_i = 16'h0080;
    for (int c = 0; c < 7; c++) begin
      if (c < 6) step();
      mem_stall = (c == 1 || c == 2 || c == 5);
      #1;
      e = pack(1, 0, 1, 0, 1, c == 6, 0, exp_idx[c], 16'h0080 + 2 * exp_idx[c]);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall cycle%0d: got %h want %h", c, obs, e);
      end
    end
    req_i = 1'b0;
    step();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL stall idle: got %h want %h", obs, 25'd0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_i();
    test_tie_round_robin();
    test_drop_mid_burst();
    test_write_d();
    test_reset_mid_burst();
`ifdef MEM_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Controller and arbiter for the shared four-word line memory.
- Accepts line-fill requests from the instruction side (I) and the data side (D).
- Grants one requester at a time using round-robin arbitration.
- Sequences a 4-beat burst, driving the word index 0→1→2→3 to the banked memory and one-hot word-select logic.
- Pulses a per-requester done on the last beat. Sits between both cache controllers and the memory datapath.

Parameters:
ADDR_W, 16, byte-address width of request and memory address buses (minimum 4).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
req_i  input  1  I-side line request; held high until done_i.
addr_i  input  ADDR_W  I-side byte address; line base = addr_i[ADDR_W-1:3].
req_d  input  1  D-side line request; held high until done_d.
wr_d  input  1  D-side write (1) / read (0); I side is always read.
addr_d  input  ADDR_W  D-side byte address.
gnt_i  output  1  I side owns memory for the current burst.
gnt_d  output  1  D side owns memory for the current burst.
mem_en  output  1  memory beat active this cycle.
mem_wr  output  1  beat is a write.
mem_addr  output  ADDR_W  {line_base, word_idx, 1'b0}.
word_idx  output  2  current beat index, 0..3.
done_i  output  1  one-cycle pulse on the final I beat.
done_d  output  1  one-cycle pulse on the final D beat.
busy  output  1  high in BURST.

Behaviour:
- State machine: IDLE, BURST. Registers: 2-bit beat count, latched line base, latched wr, owner, last_owner.
- Reset (rst==0 at edge): state=IDLE, count=0, owner=none, last_owner=I.
  - All outputs 0, mem_addr=0.
  - Overrides any in-flight burst: that burst is abandoned and no done is issued.
- IDLE: outputs gnt_*, mem_en, busy, done_* are 0. At the edge:
  - Only req_i: owner=I, latch addr_i, wr=0.
  - Only req_d: owner=D, latch addr_d and wr_d.
  - Both: grant the side not equal to last_owner. First tie after reset goes to D.
  - On grant: state=BURST, count=0.
- BURST: gnt of owner=1, mem_en=1, busy=1, word_idx=count, mem_wr=latched wr, mem_addr from the latched base.
  - count increments each cycle.
  - When count==3: done of owner=1 that same cycle; at the edge state=IDLE, last_owner=owner, owner=none.
- Latency: request high in cycle T → beat0 in T+1 → beat3 and done in T+4 → IDLE in T+5. The next grant is at earliest beat0 in T+6, so there is one turnaround cycle per burst.
- Address and wr are latched at grant. Changes on addr_*/wr_d during a burst are ignored.
- Request dropped mid-burst: burst still completes all 4 beats and done still pulses. No abort.
- Request of the owner still high in the IDLE cycle after done: treated as a new request and arbitrated normally against the other side.
- gnt_i and gnt_d are never high simultaneously. done_x is only asserted when gnt_x is also high.

Optional Feature:
MEM_STALL_EN
- Defined: adds port mem_stall (input, 1).
  - While mem_stall=1 in BURST, the count holds, all outputs hold their current values, and done is suppressed.
  - The beat completes in the first cycle with mem_stall=0.
  - mem_stall is ignored in IDLE.
- Undefined: the port is absent and behaviour is as if mem_stall=0.

Test Plan:
- Reset then req_i=1, addr_i=0x1234 → from cycle 1: gnt_i=1 for 4 cycles; mem_addr 0x1230, 0x1232, 0x1234, 0x1236; word_idx 0..3; done_i only on beat 3; IDLE next cycle.
- req_i and req_d high together from reset → D granted first; I granted after one turnaround cycle; then with both held high, grants alternate D, I, D.
- req_d=1, wr_d=1, addr_d=0x00F8 → mem_wr=1 on all 4 beats, mem_addr 0x00F8..0x00FE; addr_d changed to 0xFFFF mid-burst → no effect.
- req_i dropped after beat 1 → beats 2 and 3 still issued, done_i pulses, gnt_i falls after beat 3.
- rst=0 during beat 2 → next cycle all outputs 0, state IDLE, no done; first tie after release goes to D.
- (MEM_STALL_EN) mem_stall=1 for 2 cycles at beat 1 → word_idx stays 1 for 3 cycles; done is delayed 2 cycles.
